snake_dir_input: RTL and testbench

Button-conditioning front end for the snake game core. Synchronises and debounces the five raw push-buttons and converts direction presses into a small queue of legal turns. It releases one turn per game step, so the core sees exactly one `move_dir` change per tick. It also owns the pause toggle, which the core and its step-clock divider consume.

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_dir_input_debounce.sv | 51 +++++
 rtl/snake_dir_input.sv | 138 +++++++++++++
 tb/tb_snake_dir_input.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and helpers for the snake game: heading encoding and the
// reversal test used by the turn filter and the core.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int BTN_N = 5;

  // Opposite headings share the axis bit and differ in the sense bit.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_dir_input_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each rising edge of that level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser, stability counter and rise-pulse register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (r_s2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/snake_dir_input.sv
// Snake button front end: debounced presses become legal turns in a 2-deep
// queue released one per game tick; PAUSE toggles the paused level.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       PAUSE,
  input  logic       tick,
  output logic [1:0] move_dir,
  output logic       paused,
  output logic       turn_taken
);

  logic [BTN_N-1:0] w_raw;
  logic [BTN_N-1:0] w_press;
  logic [3:0]       w_dir_pr;
  logic             w_one;
  logic [1:0]       w_new;
  logic [1:0]       w_ref;
  logic             w_push;
  logic             w_pop;

  logic [1:0] r_q0, r_q1, r_cnt, r_dir;
  logic       r_paused, r_tt;
  logic [1:0] w_q0, w_q1, w_cnt, w_dir;
  logic       w_paused, w_tt;

  assign w_raw = {PAUSE, RIGHT, LEFT, DOWN, UP};

  for (genvar g = 0; g < BTN_N; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .i_clk  (SYS_CLK),
      .i_rst_n(RST),
      .i_raw  (w_raw[g]),
      .o_press(w_press[g])
    );
  end

  assign w_dir_pr = w_press[3:0];
  assign w_one    = (w_dir_pr != 4'd0) && ((w_dir_pr & (w_dir_pr - 4'd1)) == 4'd0);

  // Decode the single pressed direction into its heading code.
  always_comb begin
    w_new = DIR_UP;
    case (w_dir_pr)
      4'b0001: w_new = DIR_UP;
      4'b0010: w_new = DIR_DOWN;
      4'b0100: w_new = DIR_LEFT;
      4'b1000: w_new = DIR_RIGHT;
      default: w_new = DIR_UP;
    endcase
  end

  // Filter against the newest pending heading, judged on pre-pop state.
  assign w_ref  = (r_cnt == 2'd0) ? r_dir : ((r_cnt == 2'd1) ? r_q0 : r_q1);
  assign w_push = !r_paused && w_one && (w_new != w_ref) && !is_reverse(w_new, w_ref)
                  && (r_cnt != 2'd2);
  assign w_pop  = !r_paused && tick && (r_cnt != 2'd0);

  // Next-state for the queue, heading and pause; a pause press overrides both.
  always_comb begin
    w_q0     = r_q0;
    w_q1     = r_q1;
    w_cnt    = r_cnt;
    w_dir    = r_dir;
    w_paused = r_paused;
    w_tt     = 1'b0;
    if (w_press[4]) begin
      w_paused = ~r_paused;
      if (!r_paused) begin
        w_cnt = 2'd0;
      end else begin
        w_cnt = r_cnt;
      end
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            w_q0 = w_new;
          end else begin
            w_q1 = w_new;
          end
          w_cnt = r_cnt + 2'd1;
        end
        2'b01: begin
          w_dir = r_q0;
          w_q0  = r_q1;
          w_cnt = r_cnt - 2'd1;
          w_tt  = 1'b1;
        end
        // Both only possible with exactly one entry queued.
        2'b11: begin
          w_dir = r_q0;
          w_q0  = w_new;
          w_tt  = 1'b1;
        end
        default: begin
          w_cnt = r_cnt;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge SYS_CLK) begin
    if (!RST) begin
      r_q0     <= DIR_UP;
      r_q1     <= DIR_UP;
      r_cnt    <= 2'd0;
      r_dir    <= DIR_UP;
      r_paused <= 1'b0;
      r_tt     <= 1'b0;
    end else begin
      r_q0     <= w_q0;
      r_q1     <= w_q1;
      r_cnt    <= w_cnt;
      r_dir    <= w_dir;
      r_paused <= w_paused;
      r_tt     <= w_tt;
    end
  end

  assign move_dir   = r_dir;
  assign paused     = r_paused;
  assign turn_taken = r_tt;

endmodule

// File: tb/tb_snake_dir_input.sv
// Self-checking bench for snake_dir_input: directed scenarios with literal
// expectations plus randomized buttons/ticks checked every cycle against a model.
module tb_snake_dir_input;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = 5'b00000;
  logic       tick = 1'b0;
  logic [1:0] move_dir;
  logic       paused;
  logic       turn_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_dir_input #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .SYS_CLK   (clk),
    .RST       (rst_n),
    .UP        (btn[0]),
    .DOWN      (btn[1]),
    .LEFT      (btn[2]),
    .RIGHT     (btn[3]),
    .PAUSE     (btn[4]),
    .tick      (tick),
    .move_dir  (move_dir),
    .paused    (paused),
    .turn_taken(turn_taken)
  );

  // Behavioural model: per-button "disagreed for DC samples since last agreement".
  bit         m_s1[5], m_s2[5], m_lvl[5], m_rose[5], m_press[5];
  int         m_last_ok[5];
  int         m_cyc = 0;
  logic [1:0] m_q[$];
  logic [1:0] m_dir = 2'd0;
  bit         m_paused = 1'b0;
  bit         m_tt = 1'b0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int         n;
    logic [1:0] nd, rf;
    bit         do_push, do_pop, rose_now;
    m_cyc++;
    if (!rst_n) begin
      for (int b = 0; b < 5; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_rose[b] = 0; m_press[b] = 0;
        m_last_ok[b] = m_cyc;
      end
      m_q.delete();
      m_dir = 2'd0; m_paused = 0; m_tt = 0;
    end else begin
      m_tt = 0;
      n = 0; nd = 2'd0;
      for (int i = 0; i < 4; i++) begin
        if (m_press[i]) begin n++; nd = 2'(i); end
      end
      if (m_press[4]) begin
        m_paused = !m_paused;
        if (m_paused) m_q.delete();
      end else if (!m_paused) begin
        rf = (m_q.size() > 0) ? m_q[$] : m_dir;
        do_push = (n == 1) && (nd != rf) && (nd != (rf ^ 2'b01)) && (m_q.size() < 2);
        do_pop  = tick && (m_q.size() > 0);
        if (do_pop) begin m_dir = m_q.pop_front(); m_tt = 1; end
        if (do_push) m_q.push_back(nd);
      end
      for (int b = 0; b < 5; b++) begin
        rose_now = 0;
        if (m_s2[b] == m_lvl[b]) m_last_ok[b] = m_cyc;
        else if (m_cyc - m_last_ok[b] >= DC) begin
          m_lvl[b] = ~m_lvl[b];
          m_last_ok[b] = m_cyc;
          rose_now = m_lvl[b];
        end
        m_press[b] = m_rose[b];
        m_rose[b]  = rose_now;
        m_s2[b]    = m_s1[b];
        m_s1[b]    = btn[b];
      end
    end
  endtask

  // Per-cycle compare against the model, #1 after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("move_dir", move_dir, m_dir);
      check("paused", {1'b0, paused}, {1'b0, m_paused});
      check("turn_taken", {1'b0, turn_taken}, {1'b0, m_tt});
    end
  end

  task automatic tick_chk(input logic [1:0] ed, input logic et);
    tick = 1'b1;
    @(posedge clk); #2;
    check("lit_tick_dir", move_dir, ed);
    check("lit_tick_tt", {1'b0, turn_taken}, {1'b0, et});
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (10) @(negedge clk);
    btn[b] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Pulse is consumed on the 8th edge after the raw rise; tick lands on it.
  task automatic press_with_tick(input int b, input logic [1:0] ed, input logic et);
    btn[b] = 1'b1;
    repeat (7) @(negedge clk);
    tick_chk(ed, et);
    repeat (2) @(negedge clk);
    btn[b] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    btn[3] = 1'b1;
    repeat (3) @(negedge clk);
    check("lit_rst_dir", move_dir, 2'd0);
    check("lit_rst_paused", {1'b0, paused}, 2'd0);
    check("lit_rst_tt", {1'b0, turn_taken}, 2'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    btn[3] = 1'b0;
    repeat (10) @(negedge clk);
    tick_chk(2'd3, 1'b1);
    press(2);
    tick_chk(2'd3, 1'b0);
    press(0);
    press(2);
    press(1);
    tick_chk(2'd0, 1'b1);
    tick_chk(2'd2, 1'b1);
    tick_chk(2'd2, 1'b0);
    repeat (10) begin
      btn[0] = ~btn[0];
      repeat (2) @(negedge clk);
    end
    tick_chk(2'd2, 1'b0);
    press(0);
    tick_chk(2'd0, 1'b1);
    btn[0] = 1'b1; btn[2] = 1'b1;
    repeat (10) @(negedge clk);
    btn[0] = 1'b0; btn[2] = 1'b0;
    repeat (10) @(negedge clk);
    tick_chk(2'd0, 1'b0);
    press(3);
    press_with_tick(1, 2'd3, 1'b1);
    tick_chk(2'd1, 1'b1);
    tick_chk(2'd1, 1'b0);
    press(2);
    press_with_tick(4, 2'd1, 1'b0);
    check("lit_pause_on", {1'b0, paused}, 2'd1);
    tick_chk(2'd1, 1'b0);
    press(0);
    tick_chk(2'd1, 1'b0);
    press(4);
    check("lit_pause_off", {1'b0, paused}, 2'd0);
    tick_chk(2'd1, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      end
      tick  = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; btn = 5'b00000; tick = 1'b0;
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
